wakeup_broadcast: RTL and testbench
===================================

# wakeup_broadcast

Completion-side counterpart to the reservation station's issue port. Collects results from the three functional units, buffers them per FU, and arbitrates one result per cycle onto the single wakeup/forwarding bus (`wakeup_tag`/`wakeup_val`) and the ROB completion port. Drives `FU1_ready`..`FU3_ready` back to the reservation station so a unit is never issued work whose result cannot be buffered.

## Interface
- `NUM_FU`, 3: number of functional units; index n maps to `FU(n+1)_ready`.
- `BUF_DEPTH`, 2: result buffer entries per FU.
- `TAG_W`, 6: physical register tag width.
- `ROB_W`, 6: ROB index width.
- `DATA_W`, 32: result width.

Ports:
- `clk` in 1: clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `fu_done` in NUM_FU: per-FU result valid, one-cycle pulse per result.
- `fu_rd_tag` in NUM_FU*TAG_W: destination tag, FU n at [n*TAG_W +: TAG_W].
- `fu_rob_num` in NUM_FU*ROB_W: ROB index per FU.
- `fu_result` in NUM_FU*DATA_W: result value per FU.
- `FU1_ready`, `FU2_ready`, `FU3_ready` out 1 each: unit may accept a new issue.
- `wakeup_valid` out 1: broadcast carries a register write.
- `wakeup_tag` out TAG_W: broadcast tag; 0 when idle.
- `wakeup_val` out DATA_W: broadcast value; 0 when idle.
- `complete_valid` out 1: ROB entry `complete_rob_num` finished.
- `complete_rob_num` out ROB_W: ROB index of broadcast result.
- `overflow_err` out 1: sticky; a result arrived at a full buffer.

## Operation
- Per-FU FIFO, `BUF_DEPTH` entries of {rd_tag, rob_num, result}, with count `cnt[n]`.
- Candidate for FU n: FIFO head if `cnt[n]>0`; otherwise the incoming `fu_done[n]` result (bypass).
- Round-robin arbitration: search candidates starting at `rr_ptr`. Winner w is registered to the outputs. Then `rr_ptr <= (w+1) mod NUM_FU`. With no winner, `rr_ptr` holds.
- Winner from FIFO: pop. Winner by bypass: no push.
- A non-winning `fu_done[n]` pushes to FIFO n.
- Push and pop on the same FIFO in the same cycle: count unchanged, order preserved (head leaves, new result at tail).
- Push when `cnt[n]==BUF_DEPTH`: result dropped, `overflow_err <= 1` until reset. This is a protocol violation.
- `FU(n+1)_ready = (cnt[n] <= BUF_DEPTH-2)`, combinational from registered counts. This keeps one slot free for a result already in flight when ready deasserts.
- Winner with `rd_tag == 0` (store or no destination):
  - `complete_valid=1`, `complete_rob_num` driven.
  - `wakeup_valid=0`, `wakeup_tag=0`, `wakeup_val=0`.
  - Tag 0 is never broadcast.
- No winner: `wakeup_valid=0`, `complete_valid=0`, `wakeup_tag=0`, `wakeup_val=0`, `complete_rob_num=0`.

## Timing
- Reset values:
  - All `cnt` = 0, `rr_ptr` = 0.
  - `wakeup_valid`, `wakeup_tag`, `wakeup_val`, `complete_valid`, `complete_rob_num`, `overflow_err` = 0.
  - `FU1_ready`..`FU3_ready` = 1 (counts zero).
- Minimum latency: `fu_done` in cycle t gives broadcast in cycle t+1 (bypass win).
- Each losing or queued result waits at least one extra cycle per arbitration loss.
- Broadcast outputs are valid for exactly one cycle per result; the RS samples them at the following edge.
- Ready deasserts in the cycle after the push that makes `cnt[n] > BUF_DEPTH-2`.
- Reset asserted mid-operation: all buffered results are discarded. Outputs show reset values in the cycle after the reset edge.

## Structure
- Shared package: `TAG_W`, `ROB_W`, `DATA_W`, `NUM_FU`, and the result record typedef {rd_tag, rob_num, result}. The ROB and RS use the same record.
- Sub-module `result_fifo`, instantiated NUM_FU times:
  - Parameterized depth.
  - Exposes `push`, `pop`, `head`, `count`.
  - Simultaneous push/pop when full is legal.
- Arbiter and output registers live in the top.

## Test plan
- Single FU0 result (tag 12, val 0xDEADBEEF, rob 5) at t -> at t+1 `wakeup_valid=1`, tag 12, val 0xDEADBEEF, `complete_rob_num=5`. At t+2 all outputs 0.
- FU0/1/2 done the same cycle, tags 10/11/12, `rr_ptr=0`:
  - Broadcasts are 10, 11, 12 at t+1, t+2, t+3.
  - `FU2_ready`/`FU3_ready` low at t+1, back high once their entry pops.
  - `rr_ptr` ends at 0.
- FU1 result with `rd_tag=0`, rob 9 -> `complete_valid=1`, rob 9, `wakeup_valid=0`, `wakeup_tag=0`.
- Fairness: FU0 and FU1 results pending continuously -> broadcasts strictly alternate FU0, FU1, and no FIFO exceeds depth 2.
- FU2 `fu_done` while `cnt[2]=2` and FU0/FU1 win arbitration -> `overflow_err=1` and stays 1. The dropped result is never broadcast.
- Reset for one cycle while FIFOs hold 2 entries -> next cycle `wakeup_valid=0`, all ready=1, `overflow_err=0`, and no stale result is ever broadcast.

Source files
------------

// File: rtl/wakeup_broadcast_pkg.sv
// Shared types and sizes for the completion/wakeup path.
// The result record is the same one the ROB and reservation station use.
package wakeup_broadcast_pkg;

    localparam int NUM_FU    = 3;
    localparam int BUF_DEPTH = 2;
    localparam int TAG_W     = 6;
    localparam int ROB_W     = 6;
    localparam int DATA_W    = 32;

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(NUM_FU);

    // A unit may be issued work only while at least two slots are free:
    // one for the new result, one for a result already in flight.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_DEPTH - 2);
    localparam logic [PTR_W-1:0] LAST_FU   = PTR_W'(NUM_FU - 1);

    typedef struct packed {
        logic [TAG_W-1:0]  rd_tag;
        logic [ROB_W-1:0]  rob_num;
        logic [DATA_W-1:0] result;
    } result_t;

    // Round-robin successor of a functional-unit index.
    function automatic logic [PTR_W-1:0] next_fu(input logic [PTR_W-1:0] i);
        if (i == LAST_FU) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

endpackage

// File: rtl/wakeup_broadcast_if.sv
// FU-side and broadcast-side signals of the wakeup/completion block.
//
// Handshake: fu_done[n] is a one-cycle valid pulse carrying one result; there
// is no per-result ready. FU(n+1)_ready is an issue-permission signal: the RS
// must only issue to unit n while it is high, which guarantees buffer space
// for every result that later pulses fu_done[n]. Broadcast outputs
// (wakeup_* / complete_*) are valid for exactly one cycle per result and are
// never back-pressured.
interface wakeup_broadcast_if;
    import wakeup_broadcast_pkg::*;

    logic [NUM_FU-1:0]        fu_done;
    logic [NUM_FU*TAG_W-1:0]  fu_rd_tag;
    logic [NUM_FU*ROB_W-1:0]  fu_rob_num;
    logic [NUM_FU*DATA_W-1:0] fu_result;

    logic FU1_ready;
    logic FU2_ready;
    logic FU3_ready;

    logic              wakeup_valid;
    logic [TAG_W-1:0]  wakeup_tag;
    logic [DATA_W-1:0] wakeup_val;
    logic              complete_valid;
    logic [ROB_W-1:0]  complete_rob_num;
    logic              overflow_err;

    // Round-robin pointer, exposed for observation.
    logic [PTR_W-1:0]  dbg_rr_ptr;

    modport master (
        output fu_done, fu_rd_tag, fu_rob_num, fu_result,
        input  FU1_ready, FU2_ready, FU3_ready,
        input  wakeup_valid, wakeup_tag, wakeup_val,
        input  complete_valid, complete_rob_num, overflow_err,
        input  dbg_rr_ptr
    );

    modport slave (
        input  fu_done, fu_rd_tag, fu_rob_num, fu_result,
        output FU1_ready, FU2_ready, FU3_ready,
        output wakeup_valid, wakeup_tag, wakeup_val,
        output complete_valid, complete_rob_num, overflow_err,
        output dbg_rr_ptr
    );

endinterface

// File: rtl/wakeup_broadcast_result_fifo.sv
// Per-FU result buffer. Shift-style FIFO: the head is always entry 0.
// Simultaneous push and pop is legal at any fill level, including full.
// A push into a full buffer without a pop is dropped and flagged on `drop`.
module result_fifo
    import wakeup_broadcast_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  result_t                      din,
    input  logic                         pop,
    output result_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drop
);

    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int FIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [FCNT_W-1:0] FULL = FCNT_W'(DEPTH);

    result_t           mem [DEPTH];
    logic              do_push;
    logic [FCNT_W-1:0] wr_idx;

    assign drop    = push && (count == FULL) && !pop;
    assign do_push = push && !drop;
    // When popping in the same cycle the tail slides down by one.
    assign wr_idx  = pop ? (count - 1'b1) : count;
    assign head    = mem[0];

    // Occupancy count; only the count is reset, stale data is never visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (do_push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !do_push) begin
            count <= count - 1'b1;
        end
    end

    // Storage: shift toward the head on pop, write the new result at the tail.
    always_ff @(posedge clk) begin
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
        if (do_push) begin
            mem[FIDX_W'(wr_idx)] <= din;
        end
    end

endmodule

// File: rtl/wakeup_broadcast.sv
// Collects results from the functional units, buffers them per unit and
// broadcasts one per cycle on the wakeup/forwarding bus and ROB completion
// port, chosen round-robin. An empty buffer lets a fresh result bypass
// straight to arbitration for single-cycle latency.
module wakeup_broadcast
    import wakeup_broadcast_pkg::*;
(
    input logic            clk,
    input logic            reset,
    wakeup_broadcast_if.slave bus
);

    result_t          in_rec   [NUM_FU];
    result_t          head_rec [NUM_FU];
    result_t          cand_rec [NUM_FU];
    logic [CNT_W-1:0] cnt      [NUM_FU];

    logic [NUM_FU-1:0] cand_valid;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] drop;
    logic [NUM_FU-1:0] fu_ready;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    result_t          win_rec;
    logic [PTR_W-1:0] rr_ptr;

    logic              wakeup_valid_q;
    logic [TAG_W-1:0]  wakeup_tag_q;
    logic [DATA_W-1:0] wakeup_val_q;
    logic              complete_valid_q;
    logic [ROB_W-1:0]  complete_rob_num_q;
    logic              overflow_err_q;

    genvar g;
    generate
        for (g = 0; g < NUM_FU; g++) begin : g_fu
            assign in_rec[g] = '{
                rd_tag:  bus.fu_rd_tag [g*TAG_W  +: TAG_W],
                rob_num: bus.fu_rob_num[g*ROB_W  +: ROB_W],
                result:  bus.fu_result [g*DATA_W +: DATA_W]
            };

            // Buffered results go first; an empty buffer offers the new result.
            assign cand_valid[g] = (cnt[g] != '0) || bus.fu_done[g];
            assign cand_rec[g]   = (cnt[g] != '0) ? head_rec[g] : in_rec[g];

            assign pop[g]  = win_found && (win_idx == PTR_W'(g)) && (cnt[g] != '0);
            // A bypass winner is consumed directly and is not buffered.
            assign push[g] = bus.fu_done[g] &&
                             !(win_found && (win_idx == PTR_W'(g)) && (cnt[g] == '0));

            assign fu_ready[g] = (cnt[g] <= READY_MAX);

            result_fifo #(
                .DEPTH (BUF_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (push[g]),
                .din   (in_rec[g]),
                .pop   (pop[g]),
                .head  (head_rec[g]),
                .count (cnt[g]),
                .drop  (drop[g])
            );
        end
    endgenerate

    // Round-robin search starting at rr_ptr for the first unit with a candidate.
    always_comb begin
        logic [PTR_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = rr_ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!win_found && cand_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
            idx = next_fu(idx);
        end
    end

    assign win_rec = cand_rec[win_idx];

    // Register the winner onto the broadcast outputs and advance the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr             <= '0;
            wakeup_valid_q     <= 1'b0;
            wakeup_tag_q       <= '0;
            wakeup_val_q       <= '0;
            complete_valid_q   <= 1'b0;
            complete_rob_num_q <= '0;
            overflow_err_q     <= 1'b0;
        end else begin
            overflow_err_q <= overflow_err_q | (|drop);
            if (win_found) begin
                rr_ptr             <= next_fu(win_idx);
                complete_valid_q   <= 1'b1;
                complete_rob_num_q <= win_rec.rob_num;
                // Tag 0 means no destination register: complete only, no wakeup.
                if (win_rec.rd_tag != '0) begin
                    wakeup_valid_q <= 1'b1;
                    wakeup_tag_q   <= win_rec.rd_tag;
                    wakeup_val_q   <= win_rec.result;
                end else begin
                    wakeup_valid_q <= 1'b0;
                    wakeup_tag_q   <= '0;
                    wakeup_val_q   <= '0;
                end
            end else begin
                wakeup_valid_q     <= 1'b0;
                wakeup_tag_q       <= '0;
                wakeup_val_q       <= '0;
                complete_valid_q   <= 1'b0;
                complete_rob_num_q <= '0;
            end
        end
    end

    assign bus.FU1_ready        = fu_ready[0];
    assign bus.FU2_ready        = fu_ready[1];
    assign bus.FU3_ready        = fu_ready[2];
    assign bus.wakeup_valid     = wakeup_valid_q;
    assign bus.wakeup_tag       = wakeup_tag_q;
    assign bus.wakeup_val       = wakeup_val_q;
    assign bus.complete_valid   = complete_valid_q;
    assign bus.complete_rob_num = complete_rob_num_q;
    assign bus.overflow_err     = overflow_err_q;
    assign bus.dbg_rr_ptr       = rr_ptr;

endmodule

// File: tb/tb_wakeup_broadcast.sv
// Directed bench for wakeup_broadcast: single bypass, simultaneous arrivals,
// store completion, round-robin fairness, overflow, and mid-run reset.
module tb_wakeup_broadcast;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;
    int n_bcast  = 0;

    logic [5:0] exp_q[$];

    wakeup_broadcast_if bus ();

    wakeup_broadcast dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Driver tasks
    task automatic set_fu(input int n, input logic [5:0] tag, input logic [5:0] rob,
                          input logic [31:0] val);
        bus.fu_done[n]               = 1'b1;
        bus.fu_rd_tag [n*6  +: 6]    = tag;
        bus.fu_rob_num[n*6  +: 6]    = rob;
        bus.fu_result [n*32 +: 32]   = val;
    endtask

    task automatic issue(input int n, input logic [5:0] tag);
        set_fu(n, tag, tag, 32'hC0DE_0000 | 32'(tag));
    endtask

    task automatic clear_done();
        bus.fu_done = '0;
    endtask

    task automatic do_reset();
        clear_done();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Scoreboard: every broadcast must match the head of exp_q.
    task automatic sb_observe(input string name);
        if (bus.wakeup_valid) begin
            n_bcast++;
            if (exp_q.size() == 0) begin
                check({name, "_extra"}, bus.wakeup_valid, 1'b0);
            end else begin
                check(name, bus.wakeup_tag, exp_q.pop_front());
            end
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_wv"},  bus.wakeup_valid,     1'b0);
        check({name, "_tag"}, bus.wakeup_tag,       6'd0);
        check({name, "_val"}, bus.wakeup_val,       32'd0);
        check({name, "_cv"},  bus.complete_valid,   1'b0);
        check({name, "_rob"}, bus.complete_rob_num, 6'd0);
    endtask

    task automatic check_all_ready(input string name);
        check({name, "_r1"}, bus.FU1_ready, 1'b1);
        check({name, "_r2"}, bus.FU2_ready, 1'b1);
        check({name, "_r3"}, bus.FU3_ready, 1'b1);
    endtask

    initial begin
        bus.fu_done    = '0;
        bus.fu_rd_tag  = '0;
        bus.fu_rob_num = '0;
        bus.fu_result  = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check_idle("rst");
        check_all_ready("rst");
        check("rst_ovf", bus.overflow_err, 1'b0);
        check("rst_rr",  bus.dbg_rr_ptr,   2'd0);

        // Single FU0 result: one-cycle bypass latency
        set_fu(0, 6'd12, 6'd5, 32'hDEADBEEF);
        step();
        clear_done();
        check("single_wv",  bus.wakeup_valid,     1'b1);
        check("single_tag", bus.wakeup_tag,       6'd12);
        check("single_val", bus.wakeup_val,       32'hDEADBEEF);
        check("single_cv",  bus.complete_valid,   1'b1);
        check("single_rob", bus.complete_rob_num, 6'd5);
        step();
        check_idle("single_after");

        // Three results in one cycle, starting from rr_ptr = 0
        do_reset();
        issue(0, 6'd10);
        issue(1, 6'd11);
        issue(2, 6'd12);
        step();
        clear_done();
        check("tri1_tag", bus.wakeup_tag, 6'd10);
        check("tri1_r1",  bus.FU1_ready,  1'b1);
        check("tri1_r2",  bus.FU2_ready,  1'b0);
        check("tri1_r3",  bus.FU3_ready,  1'b0);
        step();
        check("tri2_tag", bus.wakeup_tag, 6'd11);
        check("tri2_val", bus.wakeup_val, 32'hC0DE_000B);
        check("tri2_r2",  bus.FU2_ready,  1'b1);
        check("tri2_r3",  bus.FU3_ready,  1'b0);
        step();
        check("tri3_tag", bus.wakeup_tag, 6'd12);
        check("tri3_rob", bus.complete_rob_num, 6'd12);
        check("tri3_r3",  bus.FU3_ready,  1'b1);
        check("tri3_rr",  bus.dbg_rr_ptr, 2'd0);
        step();
        check_idle("tri_after");

        // Store (rd_tag 0) from FU1: completion only
        set_fu(1, 6'd0, 6'd9, 32'h1234_5678);
        step();
        clear_done();
        check("st_cv",  bus.complete_valid,   1'b1);
        check("st_rob", bus.complete_rob_num, 6'd9);
        check("st_wv",  bus.wakeup_valid,     1'b0);
        check("st_tag", bus.wakeup_tag,       6'd0);
        check("st_val", bus.wakeup_val,       32'd0);
        check("st_rr",  bus.dbg_rr_ptr,       2'd2);

        // Fairness: FU0 and FU1 issue whenever ready for 8 cycles
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(6'(20 + i));
            if (i < 4) exp_q.push_back(6'(40 + i));
        end
        n_bcast = 0;
        begin
            logic [5:0] t0;
            logic [5:0] t1;
            t0 = 6'd20;
            t1 = 6'd40;
            for (int c = 0; c < 14; c++) begin
                if (c < 8 && bus.FU1_ready) begin
                    issue(0, t0);
                    t0 = t0 + 6'd1;
                end
                if (c < 8 && bus.FU2_ready) begin
                    issue(1, t1);
                    t1 = t1 + 6'd1;
                end
                step();
                clear_done();
                sb_observe("fair");
            end
        end
        check("fair_count", n_bcast, 9);
        check("fair_left",  exp_q.size(), 0);
        check("fair_ovf",   bus.overflow_err, 1'b0);
        check("fair_rr",    bus.dbg_rr_ptr, 2'd1);

        // Overflow: FU2 pushed while full as FU0/FU1 win arbitration
        exp_q.delete();
        exp_q = '{6'd51, 6'd52, 6'd50, 6'd55, 6'd53, 6'd56};
        n_bcast = 0;
        for (int c = 0; c < 9; c++) begin
            case (c)
                0: begin issue(0, 6'd50); issue(1, 6'd51); issue(2, 6'd52); end
                1: begin issue(1, 6'd55); issue(2, 6'd53); end
                2: issue(2, 6'd56);
                3: issue(2, 6'd57);
                default: ;
            endcase
            step();
            clear_done();
            sb_observe("ovf");
            if (c == 2) check("ovf_pre",  bus.overflow_err, 1'b0);
            if (c == 3) check("ovf_set",  bus.overflow_err, 1'b1);
        end
        check("ovf_count",  n_bcast, 6);
        check("ovf_left",   exp_q.size(), 0);
        check("ovf_sticky", bus.overflow_err, 1'b1);

        // Reset while buffers hold results
        issue(0, 6'd60); issue(1, 6'd61); issue(2, 6'd62);
        step();
        check("rst2_first", bus.wakeup_tag, 6'd60);
        issue(0, 6'd63); issue(1, 6'd64); issue(2, 6'd65);
        step();
        check("rst2_second", bus.wakeup_tag, 6'd61);
        check("rst2_r3low",  bus.FU3_ready,  1'b0);
        do_reset();
        check_idle("rst2");
        check_all_ready("rst2");
        check("rst2_ovf", bus.overflow_err, 1'b0);
        check("rst2_rr",  bus.dbg_rr_ptr,   2'd0);
        exp_q.delete();
        n_bcast = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            sb_observe("rst2_stale");
            check("rst2_cv", bus.complete_valid, 1'b0);
        end
        check("rst2_count", n_bcast, 0);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
